tlc_multi: RTL and testbench

- Parametrised successor to the two-road traffic light controller.
- Serves N_PHASES conflicting vehicle phases in round-robin order. Vehicles actuate the controller through per-phase demand and gap-out extension.
- Adds all-red clearance, a latched pedestrian request served as an exclusive walk interval, and a flash (fault/night) mode.
- Sits at top of the intersection controller and drives lamp drivers directly.

---
 rtl/tlc_multi.sv | 220 ++++++++++++++++++++++
 tb/tb_tlc_multi.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tlc_multi.sv
// Multi-phase actuated traffic light controller: round-robin vehicle phases with
// gap-out extension, all-red clearance, exclusive pedestrian walk and flash mode.
module tlc_multi #(
    parameter int N_PHASES    = 4,
    parameter int CNT_W       = 8,
    parameter int T_GREEN_MIN = 4,
    parameter int T_GREEN_MAX = 12,
    parameter int T_EXT       = 3,
    parameter int T_YELLOW    = 2,
    parameter int T_ALLRED    = 1,
    parameter int T_PED       = 4,
    parameter int T_FLASH     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PHASES-1:0]           veh_req,
    input  logic                          ped_req,
    input  logic                          flash_mode,
    output logic [3*N_PHASES-1:0]         lights,
    output logic                          ped_walk,
    output logic [$clog2(N_PHASES)-1:0]   cur_phase,
    output logic                          ped_pending
);

    localparam int PW = $clog2(N_PHASES);

    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
    localparam logic [CNT_W-1:0] T_GMIN_C    = CNT_W'(T_GREEN_MIN);
    localparam logic [CNT_W-1:0] T_GMAX_C    = CNT_W'(T_GREEN_MAX);
    localparam logic [CNT_W-1:0] T_EXT_C     = CNT_W'(T_EXT);
    localparam logic [CNT_W-1:0] T_YELLOW_C  = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] T_ALLRED_C  = CNT_W'(T_ALLRED);
    localparam logic [CNT_W-1:0] T_PED_C     = CNT_W'(T_PED);
    localparam logic [CNT_W-1:0] T_FLASH_C   = CNT_W'(T_FLASH);
    localparam logic [3*N_PHASES-1:0] ALL_RED_LAMPS = {N_PHASES{3'b100}};

    typedef enum logic [2:0] {
        ST_ALL_RED,
        ST_GREEN,
        ST_YELLOW,
        ST_PED,
        ST_FLASH
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        timer_q, timer_d;
    logic [CNT_W-1:0]        green_cnt_q, green_cnt_d;
    logic [CNT_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [PW-1:0]           cur_phase_q, cur_phase_d;
    logic [N_PHASES-1:0]     dem_q, dem_d;
    logic                    ped_pending_q, ped_pending_d;
    logic                    blink_q, blink_d;
    logic [3*N_PHASES-1:0]   lights_q, lights_d;
    logic                    ped_walk_q, ped_walk_d;

    logic [PW-1:0]           nxt_phase;
    logic                    conflict;
    logic                    enter_green;
    logic                    enter_ped;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE_C;
    endfunction

    function automatic logic [CNT_W-1:0] floor_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - ONE_C;
    endfunction

    assign conflict = (|dem_q) | ped_pending_q | flash_mode;

    // Round-robin search starting after the phase last served; falls back to the next phase.
    always_comb begin
        int            idx_i;
        logic [PW-1:0] idx;
        logic          found;
        idx_i     = 0;
        idx       = '0;
        found     = 1'b0;
        nxt_phase = PW'((int'(cur_phase_q) + 1) % N_PHASES);
        for (int k = 1; k <= N_PHASES; k++) begin
            idx_i = (int'(cur_phase_q) + k) % N_PHASES;
            idx   = PW'(idx_i);
            if (!found && dem_q[idx]) begin
                nxt_phase = idx;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cur_phase_d = cur_phase_q;
        green_cnt_d = green_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        blink_d     = blink_q;
        enter_green = 1'b0;
        enter_ped   = 1'b0;
        case (state_q)
            ST_ALL_RED: begin
                if (timer_q <= ONE_C) begin
                    if (flash_mode) begin
                        state_d = ST_FLASH;
                        timer_d = T_FLASH_C;
                        blink_d = 1'b1;
                    end else if (ped_pending_q) begin
                        state_d   = ST_PED;
                        timer_d   = T_PED_C;
                        enter_ped = 1'b1;
                    end else begin
                        state_d     = ST_GREEN;
                        cur_phase_d = nxt_phase;
                        green_cnt_d = ONE_C;
                        gap_cnt_d   = T_EXT_C;
                        enter_green = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - ONE_C;
                end
            end
            ST_GREEN: begin
                green_cnt_d = sat_inc(green_cnt_q);
                gap_cnt_d   = veh_req[cur_phase_q] ? T_EXT_C : floor_dec(gap_cnt_q);
                if ((green_cnt_q >= T_GMIN_C) && conflict &&
                    ((gap_cnt_q == '0) || (green_cnt_q >= T_GMAX_C) || flash_mode)) begin
                    state_d = ST_YELLOW;
                    timer_d = T_YELLOW_C;
                end
            end
            ST_YELLOW, ST_PED: begin
                if (timer_q <= ONE_C) begin
                    state_d = ST_ALL_RED;
                    timer_d = T_ALLRED_C;
                end else begin
                    timer_d = timer_q - ONE_C;
                end
            end
            ST_FLASH: begin
                if (!flash_mode) begin
                    state_d = ST_ALL_RED;
                    timer_d = T_ALLRED_C;
                end else if (timer_q <= ONE_C) begin
                    blink_d = ~blink_q;
                    timer_d = T_FLASH_C;
                end else begin
                    timer_d = timer_q - ONE_C;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                timer_d = T_ALLRED_C;
            end
        endcase
    end

    // Request latches: entering service clears a request even if it is re-asserted that cycle.
    always_comb begin
        dem_d = dem_q;
        for (int i = 0; i < N_PHASES; i++) begin
            if (enter_green && (cur_phase_d == PW'(i))) begin
                dem_d[i] = 1'b0;
            end else if (veh_req[i] && !((state_q == ST_GREEN) && (cur_phase_q == PW'(i)))) begin
                dem_d[i] = 1'b1;
            end
        end
        ped_pending_d = ped_pending_q;
        if (enter_ped) begin
            ped_pending_d = 1'b0;
        end else if (ped_req && (state_q != ST_PED)) begin
            ped_pending_d = 1'b1;
        end
    end

    // Lamp decode from the next state so lamps change on the same edge as the state.
    always_comb begin
        lights_d = ALL_RED_LAMPS;
        for (int i = 0; i < N_PHASES; i++) begin
            case (state_d)
                ST_GREEN:  lights_d[3*i +: 3] = (cur_phase_d == PW'(i)) ? 3'b001 : 3'b100;
                ST_YELLOW: lights_d[3*i +: 3] = (cur_phase_d == PW'(i)) ? 3'b010 : 3'b100;
                ST_FLASH:  lights_d[3*i +: 3] = (i == 0) ? {1'b0, blink_d, 1'b0}
                                                         : {blink_d, 2'b00};
                default:   lights_d[3*i +: 3] = 3'b100;
            endcase
        end
        ped_walk_d = (state_d == ST_PED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ALL_RED;
            timer_q       <= T_ALLRED_C;
            cur_phase_q   <= PW'(N_PHASES - 1);
            dem_q         <= '0;
            ped_pending_q <= 1'b0;
            green_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            blink_q       <= 1'b0;
            lights_q      <= ALL_RED_LAMPS;
            ped_walk_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cur_phase_q   <= cur_phase_d;
            dem_q         <= dem_d;
            ped_pending_q <= ped_pending_d;
            green_cnt_q   <= green_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            blink_q       <= blink_d;
            lights_q      <= lights_d;
            ped_walk_q    <= ped_walk_d;
        end
    end

    assign lights      = lights_q;
    assign ped_walk    = ped_walk_q;
    assign cur_phase   = cur_phase_q;
    assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_tlc_multi.sv
// Directed bench for tlc_multi: every cycle of each scenario is checked against
// lamp patterns built from the expected controller state.
module tb_tlc_multi;

    localparam int N = 4;
    localparam int K_AR = 0, K_G = 1, K_Y = 2, K_F = 3, K_PED = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     veh_req = '0;
    logic             ped_req = 1'b0;
    logic             flash_mode = 1'b0;
    logic [3*N-1:0]   lights;
    logic             ped_walk;
    logic [1:0]       cur_phase;
    logic             ped_pending;

    int total = 0;
    int bad   = 0;

    tlc_multi dut (
        .clk         (clk),
        .rst         (rst),
        .veh_req     (veh_req),
        .ped_req     (ped_req),
        .flash_mode  (flash_mode),
        .lights      (lights),
        .ped_walk    (ped_walk),
        .cur_phase   (cur_phase),
        .ped_pending (ped_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [3*N-1:0] exp_lights(input int kind, input int p, input bit b);
        logic [3*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            case (kind)
                K_G:     v[3*i +: 3] = (i == p) ? 3'b001 : 3'b100;
                K_Y:     v[3*i +: 3] = (i == p) ? 3'b010 : 3'b100;
                K_F:     v[3*i +: 3] = (i == 0) ? {1'b0, b, 1'b0} : {b, 2'b00};
                default: v[3*i +: 3] = 3'b100;
            endcase
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int kind, input int p, input bit b, input string tag);
        tick();
        chk({tag, ".lights"}, 32'(lights), 32'(exp_lights(kind, p, b)));
        chk({tag, ".walk"}, 32'(ped_walk), (kind == K_PED) ? 32'd1 : 32'd0);
    endtask

    task automatic do_reset(input int n, input string tag);
        rst = 1'b1;
        repeat (n) tick();
        chk({tag, ".lights"}, 32'(lights), 32'(exp_lights(K_AR, 0, 1'b0)));
        chk({tag, ".walk"}, 32'(ped_walk), 32'd0);
        chk({tag, ".phase"}, 32'(cur_phase), 32'd3);
        chk({tag, ".pending"}, 32'(ped_pending), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        // Reset then rest in phase 0 green with no demand.
        do_reset(3, "rst0");
        step(K_G, 0, 0, "rest.g_entry");
        chk("rest.phase", 32'(cur_phase), 32'd0);
        repeat (10) step(K_G, 0, 0, "rest.hold");

        // Phase 2 demand: minimum green, skip phase 1.
        do_reset(1, "rst1");
        step(K_G, 0, 0, "skip.g1");
        veh_req = 4'b0100;
        step(K_G, 0, 0, "skip.g2");
        veh_req = 4'b0000;
        step(K_G, 0, 0, "skip.g3");
        step(K_G, 0, 0, "skip.g4");
        step(K_Y, 0, 0, "skip.y1");
        step(K_Y, 0, 0, "skip.y2");
        step(K_AR, 0, 0, "skip.ar");
        step(K_G, 2, 0, "skip.g_p2");
        chk("skip.phase", 32'(cur_phase), 32'd2);
        repeat (6) step(K_G, 2, 0, "skip.p2_rest");

        // Continuous extension on phase 0 maxes out at 12 cycles.
        do_reset(1, "rst2");
        step(K_G, 0, 0, "max.g1");
        veh_req = 4'b0001;
        step(K_G, 0, 0, "max.g2");
        veh_req = 4'b0011;
        step(K_G, 0, 0, "max.g3");
        veh_req = 4'b0001;
        repeat (9) step(K_G, 0, 0, "max.g4_12");
        step(K_Y, 0, 0, "max.y1");
        step(K_Y, 0, 0, "max.y2");
        step(K_AR, 0, 0, "max.ar");
        veh_req = 4'b0000;
        step(K_G, 1, 0, "max.g_p1");
        chk("max.phase", 32'(cur_phase), 32'd1);

        // Pedestrian walk with simultaneous vehicle request; second press ignored.
        do_reset(1, "rst3");
        step(K_G, 0, 0, "ped.g1");
        ped_req = 1'b1;
        veh_req = 4'b0100;
        step(K_G, 0, 0, "ped.g2");
        ped_req = 1'b0;
        veh_req = 4'b0000;
        chk("ped.pending_set", 32'(ped_pending), 32'd1);
        step(K_G, 0, 0, "ped.g3");
        step(K_G, 0, 0, "ped.g4");
        step(K_Y, 0, 0, "ped.y1");
        step(K_Y, 0, 0, "ped.y2");
        step(K_AR, 0, 0, "ped.ar1");
        step(K_PED, 0, 0, "ped.w1");
        chk("ped.pending_clr", 32'(ped_pending), 32'd0);
        ped_req = 1'b1;
        step(K_PED, 0, 0, "ped.w2");
        ped_req = 1'b0;
        chk("ped.pending_ignored", 32'(ped_pending), 32'd0);
        step(K_PED, 0, 0, "ped.w3");
        step(K_PED, 0, 0, "ped.w4");
        step(K_AR, 0, 0, "ped.ar2");
        step(K_G, 2, 0, "ped.g_p2");
        chk("ped.phase", 32'(cur_phase), 32'd2);
        repeat (6) step(K_G, 2, 0, "ped.p2_rest");

        // Flash request during green: green completes, then blinking, then resume.
        do_reset(1, "rst4");
        step(K_G, 0, 0, "fl.g1");
        step(K_G, 0, 0, "fl.g2");
        flash_mode = 1'b1;
        step(K_G, 0, 0, "fl.g3");
        step(K_G, 0, 0, "fl.g4");
        step(K_Y, 0, 0, "fl.y1");
        step(K_Y, 0, 0, "fl.y2");
        step(K_AR, 0, 0, "fl.ar1");
        step(K_F, 0, 1, "fl.on1");
        step(K_F, 0, 1, "fl.on2");
        step(K_F, 0, 0, "fl.off1");
        step(K_F, 0, 0, "fl.off2");
        step(K_F, 0, 1, "fl.on3");
        flash_mode = 1'b0;
        step(K_AR, 0, 0, "fl.ar2");
        step(K_G, 1, 0, "fl.g_p1");
        chk("fl.phase", 32'(cur_phase), 32'd1);

        // Reset during yellow discards pending phase 3 demand.
        do_reset(1, "rst5");
        step(K_G, 0, 0, "ry.g1");
        veh_req = 4'b1000;
        step(K_G, 0, 0, "ry.g2");
        veh_req = 4'b0000;
        step(K_G, 0, 0, "ry.g3");
        step(K_G, 0, 0, "ry.g4");
        step(K_Y, 0, 0, "ry.y1");
        do_reset(1, "ry.rst");
        step(K_G, 0, 0, "ry.g_p0");
        chk("ry.phase", 32'(cur_phase), 32'd0);
        repeat (5) step(K_G, 0, 0, "ry.p0_rest");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
